// File: rtl/rd_req_issuer_pkg.sv
// Shared definitions for the read-request issuer: lane FSM encoding and AXI
// length field width.
package rd_req_issuer_pkg;

    localparam int AXI_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        LANE_IDLE  = 2'd0,
        LANE_ISSUE = 2'd1,
        LANE_DRAIN = 2'd2,
        LANE_DONE  = 2'd3
    } lane_state_e;

endpackage

// File: rtl/rd_req_issuer_if.sv
// Per-lane AXI read-address bus plus the per-lane "last beat received" pulse.
interface rd_req_issuer_if #(
    parameter int NUM_AXI        = 4,
    parameter int AXI_ADDR_WIDTH = 32
);
    import rd_req_issuer_pkg::*;

    logic [NUM_AXI-1:0]                m_arvalid;
    logic [NUM_AXI-1:0]                m_arready;
    logic [NUM_AXI*AXI_ADDR_WIDTH-1:0] m_araddr;
    logic [NUM_AXI*AXI_LEN_WIDTH-1:0]  m_arlen;
    logic [NUM_AXI-1:0]                m_rlast_hs;

    modport master (
        output m_arvalid, m_araddr, m_arlen,
        input  m_arready, m_rlast_hs
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen,
        output m_arready, m_rlast_hs
    );
endinterface

// File: rtl/rd_req_issuer_lane.sv
// One AXI read lane: splits its share of the request into bursts, limits the
// number of bursts in flight and reports when everything has come back.
module rd_req_lane
    import rd_req_issuer_pkg::*;
#(
    parameter int TX_SIZE_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int BEAT_BYTES      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      accept,
    input  logic                      release_all,
    input  logic [TX_SIZE_WIDTH-1:0]  size,
    input  logic [AXI_ADDR_WIDTH-1:0] start_addr,
    input  logic                      arready,
    input  logic                      rlast_hs,
    output logic                      arvalid,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [AXI_LEN_WIDTH-1:0]  arlen,
    output logic                      done,
    output logic                      done_next,
    output logic                      idle_next,
    output logic                      rlast_err
);
    localparam int OUT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_WIDTH = AXI_LEN_WIDTH + 1;

    lane_state_e               state_r, state_s;
    logic [AXI_ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [TX_SIZE_WIDTH-1:0]  rem_r, rem_s;
    logic [OUT_WIDTH-1:0]      out_r, out_s;
    logic                      arvalid_r, arvalid_s;
    logic [AXI_ADDR_WIDTH-1:0] araddr_r;
    logic [AXI_LEN_WIDTH-1:0]  arlen_r, arlen_s;
    logic                      ar_hs_s, rlast_ok_s;
    logic [BEAT_WIDTH-1:0]     beats_s;

    // Next-state, counter and output-register values for the lane.
    always_comb begin
        ar_hs_s    = arvalid_r & arready;
        rlast_ok_s = rlast_hs & (out_r != OUT_WIDTH'(0));
        rlast_err  = rlast_hs & (out_r == OUT_WIDTH'(0));
        beats_s    = BEAT_WIDTH'(arlen_r) + BEAT_WIDTH'(1);
        state_s    = state_r;
        addr_s     = addr_r;
        rem_s      = rem_r;
        out_s      = out_r;
        arvalid_s  = 1'b0;
        arlen_s    = AXI_LEN_WIDTH'(0);

        // Burst accepted on AR: advance address (wraps naturally) and remaining.
        if (ar_hs_s) begin
            addr_s = addr_r + AXI_ADDR_WIDTH'(beats_s) * AXI_ADDR_WIDTH'(BEAT_BYTES);
            rem_s  = rem_r - TX_SIZE_WIDTH'(beats_s);
        end else begin
            addr_s = addr_r;
            rem_s  = rem_r;
        end

        // Simultaneous issue and completion cancel out.
        case ({ar_hs_s, rlast_ok_s})
            2'b10:   out_s = out_r + OUT_WIDTH'(1);
            2'b01:   out_s = out_r - OUT_WIDTH'(1);
            default: out_s = out_r;
        endcase

        case (state_r)
            LANE_IDLE: begin
                if (accept) begin
                    addr_s  = start_addr;
                    rem_s   = size;
                    out_s   = OUT_WIDTH'(0);
                    state_s = (size == TX_SIZE_WIDTH'(0)) ? LANE_DONE : LANE_ISSUE;
                end else begin
                    state_s = LANE_IDLE;
                end
            end
            LANE_ISSUE: begin
                if (rem_s == TX_SIZE_WIDTH'(0)) begin
                    state_s = LANE_DRAIN;
                end else begin
                    state_s = LANE_ISSUE;
                end
            end
            LANE_DRAIN: begin
                if (out_s == OUT_WIDTH'(0)) begin
                    state_s = LANE_DONE;
                end else begin
                    state_s = LANE_DRAIN;
                end
            end
            LANE_DONE: begin
                if (release_all) begin
                    state_s = LANE_IDLE;
                end else begin
                    state_s = LANE_DONE;
                end
            end
            default: state_s = LANE_IDLE;
        endcase

        // AR outputs are registered from the next-state view of the lane.
        if (state_s == LANE_ISSUE) begin
            arvalid_s = (out_s < OUT_WIDTH'(MAX_OUTSTANDING));
            if (rem_s > TX_SIZE_WIDTH'(MAX_BURST_LEN)) begin
                arlen_s = AXI_LEN_WIDTH'(MAX_BURST_LEN - 1);
            end else begin
                arlen_s = AXI_LEN_WIDTH'(rem_s - TX_SIZE_WIDTH'(1));
            end
        end else begin
            arvalid_s = 1'b0;
            arlen_s   = AXI_LEN_WIDTH'(0);
        end
    end

    assign done_next = (state_s == LANE_DONE);
    assign idle_next = (state_s == LANE_IDLE);
    assign done      = (state_r == LANE_DONE);
    assign arvalid   = arvalid_r;
    assign araddr    = araddr_r;
    assign arlen     = arlen_r;

    // Lane state, counters and AR output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= LANE_IDLE;
            addr_r    <= AXI_ADDR_WIDTH'(0);
            rem_r     <= TX_SIZE_WIDTH'(0);
            out_r     <= OUT_WIDTH'(0);
            arvalid_r <= 1'b0;
            araddr_r  <= AXI_ADDR_WIDTH'(0);
            arlen_r   <= AXI_LEN_WIDTH'(0);
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            rem_r     <= rem_s;
            out_r     <= out_s;
            arvalid_r <= arvalid_s;
            araddr_r  <= addr_s;
            arlen_r   <= arlen_s;
        end
    end
endmodule

// File: rtl/rd_req_issuer.sv
// Read-request issuer: fans one request out to NUM_AXI independent AXI read
// lanes, signals completion once every lane has drained, flags protocol errors.
module rd_req_issuer
    import rd_req_issuer_pkg::*;
#(
    parameter int NUM_AXI         = 4,
    parameter int TX_SIZE_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int BEAT_BYTES      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rx_req,
    input  logic [TX_SIZE_WIDTH-1:0]          rx_req_size,
    input  logic [NUM_AXI*AXI_ADDR_WIDTH-1:0] rx_addr,
    output logic                              req_ready,
    output logic                              rd_done,
    output logic                              err_drop,
    output logic                              err_rlast,
    rd_req_issuer_if.master                   ar
);
    logic                              accept_s;
    logic                              all_done_s;
    logic [NUM_AXI-1:0]                arvalid_s, done_s, done_next_s, idle_next_s, rlast_err_s;
    logic [NUM_AXI*AXI_ADDR_WIDTH-1:0] araddr_s;
    logic [NUM_AXI*AXI_LEN_WIDTH-1:0]  arlen_s;
    logic                              req_ready_r, rd_done_r, err_drop_r, err_rlast_r;

    assign accept_s   = rx_req & req_ready_r;
    assign all_done_s = &done_s;

    for (genvar i = 0; i < NUM_AXI; i++) begin : g_lane
        rd_req_lane #(
            .TX_SIZE_WIDTH  (TX_SIZE_WIDTH),
            .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
            .MAX_BURST_LEN  (MAX_BURST_LEN),
            .BEAT_BYTES     (BEAT_BYTES),
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .accept     (accept_s),
            .release_all(all_done_s),
            .size       (rx_req_size),
            .start_addr (rx_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]),
            .arready    (ar.m_arready[i]),
            .rlast_hs   (ar.m_rlast_hs[i]),
            .arvalid    (arvalid_s[i]),
            .araddr     (araddr_s[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]),
            .arlen      (arlen_s[i*AXI_LEN_WIDTH +: AXI_LEN_WIDTH]),
            .done       (done_s[i]),
            .done_next  (done_next_s[i]),
            .idle_next  (idle_next_s[i]),
            .rlast_err  (rlast_err_s[i])
        );
    end

    assign ar.m_arvalid = arvalid_s;
    assign ar.m_araddr  = araddr_s;
    assign ar.m_arlen   = arlen_s;
    assign req_ready    = req_ready_r;
    assign rd_done      = rd_done_r;
    assign err_drop     = err_drop_r;
    assign err_rlast    = err_rlast_r;

    // Ready / completion pulse registers and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_r <= 1'b1;
            rd_done_r   <= 1'b0;
            err_drop_r  <= 1'b0;
            err_rlast_r <= 1'b0;
        end else begin
            req_ready_r <= &idle_next_s;
            rd_done_r   <= (&done_next_s) & ~all_done_s;
            err_drop_r  <= err_drop_r | (rx_req & ~req_ready_r);
            err_rlast_r <= err_rlast_r | (|rlast_err_s);
        end
    end
endmodule

// File: tb/tb_rd_req_issuer.sv
// Directed bench for rd_req_issuer with a queue-based burst model and a
// per-lane read-data responder that returns rlast a burst-length later.
module tb_rd_req_issuer;
    localparam int NUM_AXI = 4;
    localparam int TXW     = 10;
    localparam int AW      = 32;
    localparam int MBL     = 16;
    localparam int BB      = 8;
    localparam int MO      = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  rx_req;
    logic [TXW-1:0]        rx_req_size;
    logic [NUM_AXI*AW-1:0] rx_addr;
    logic                  req_ready, rd_done, err_drop, err_rlast;

    rd_req_issuer_if #(.NUM_AXI(NUM_AXI), .AXI_ADDR_WIDTH(AW)) ar ();

    rd_req_issuer #(
        .NUM_AXI(NUM_AXI), .TX_SIZE_WIDTH(TXW), .AXI_ADDR_WIDTH(AW),
        .MAX_BURST_LEN(MBL), .BEAT_BYTES(BB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .rx_req(rx_req), .rx_req_size(rx_req_size),
        .rx_addr(rx_addr), .req_ready(req_ready), .rd_done(rd_done),
        .err_drop(err_drop), .err_rlast(err_rlast), .ar(ar)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // model state
    int          cyc = 0;
    logic [31:0] mq_addr [NUM_AXI][$];
    logic [7:0]  mq_len  [NUM_AXI][$];
    int          m_out   [NUM_AXI];
    bit          m_busy = 1'b0, m_alldone = 1'b0, m_req_ready = 1'b1, m_rd_done = 1'b0;
    bit          m_err_drop = 1'b0, m_err_rlast = 1'b0;
    int          due_q   [NUM_AXI][$];
    logic [31:0] obs_addr [NUM_AXI][$];
    logic [7:0]  obs_len  [NUM_AXI][$];
    bit [NUM_AXI-1:0] hold  = '0;
    bit [NUM_AXI-1:0] stray = '0;
    int          done_cnt = 0;
    int          arvalid_seen = 0;
    int          base [NUM_AXI];
    int          done0, seen0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit exp_valid(input int i);
        return m_busy && !m_alldone && (mq_addr[i].size() > 0) && (m_out[i] < MO);
    endfunction

    task automatic model_accept();
        for (int i = 0; i < NUM_AXI; i++) begin
            logic [31:0] a;
            int rem;
            a   = rx_addr[i*AW +: AW];
            rem = int'(rx_req_size);
            while (rem > 0) begin
                int b;
                b = (rem > MBL) ? MBL : rem;
                mq_addr[i].push_back(a);
                mq_len[i].push_back(8'(b - 1));
                a   = a + 32'(b * BB);
                rem = rem - b;
            end
        end
    endtask

    // Behavioural model: advances on each rising edge from the stimulus.
    always @(posedge clk) begin
        bit [NUM_AXI-1:0] hs;
        bit fin;
        cyc++;
        for (int i = 0; i < NUM_AXI; i++) begin
            hs[i] = exp_valid(i) && (ar.m_arready[i] === 1'b1);
            if (ar.m_arvalid[i] === 1'b1 && ar.m_arready[i] === 1'b1) begin
                obs_addr[i].push_back(ar.m_araddr[i*AW +: AW]);
                obs_len[i].push_back(ar.m_arlen[i*8 +: 8]);
            end
        end
        if (reset) begin
            for (int i = 0; i < NUM_AXI; i++) begin
                mq_addr[i].delete();
                mq_len[i].delete();
                m_out[i] = 0;
            end
            m_busy = 1'b0; m_alldone = 1'b0; m_req_ready = 1'b1; m_rd_done = 1'b0;
            m_err_drop = 1'b0; m_err_rlast = 1'b0;
        end else begin
            m_rd_done = 1'b0;
            if (rx_req && !m_req_ready) m_err_drop = 1'b1;
            for (int i = 0; i < NUM_AXI; i++) begin
                if (hs[i]) begin
                    due_q[i].push_back(cyc + int'(mq_len[i][0]) + 1);
                    void'(mq_addr[i].pop_front());
                    void'(mq_len[i].pop_front());
                end
                if (ar.m_rlast_hs[i] === 1'b1) begin
                    if (m_out[i] > 0) m_out[i]--;
                    else m_err_rlast = 1'b1;
                end
                if (hs[i]) m_out[i]++;
            end
            if (m_alldone) begin
                m_alldone = 1'b0; m_busy = 1'b0; m_req_ready = 1'b1;
            end else if (rx_req && m_req_ready) begin
                m_busy = 1'b1; m_req_ready = 1'b0;
                model_accept();
            end
            if (m_busy && !m_alldone) begin
                fin = 1'b1;
                for (int i = 0; i < NUM_AXI; i++)
                    if (mq_addr[i].size() != 0 || m_out[i] != 0) fin = 1'b0;
                if (fin) begin m_rd_done = 1'b1; m_alldone = 1'b1; end
            end
        end
    end

    // Read-data responder: one rlast per lane per cycle once its burst is due.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < NUM_AXI; i++) begin
            logic fire;
            fire = 1'b0;
            if (!hold[i] && due_q[i].size() > 0) begin
                if (due_q[i][0] <= cyc) begin
                    fire = 1'b1;
                    void'(due_q[i].pop_front());
                end
            end
            ar.m_rlast_hs[i] = fire | stray[i];
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(m_req_ready));
            chk("rd_done",   32'(rd_done),   32'(m_rd_done));
            chk("err_drop",  32'(err_drop),  32'(m_err_drop));
            chk("err_rlast", 32'(err_rlast), 32'(m_err_rlast));
            for (int i = 0; i < NUM_AXI; i++) begin
                logic ev;
                ev = exp_valid(i);
                chk($sformatf("arvalid[%0d]", i), 32'(ar.m_arvalid[i]), 32'(ev));
                if (ev) begin
                    chk($sformatf("araddr[%0d]", i), ar.m_araddr[i*AW +: AW], mq_addr[i][0]);
                    chk($sformatf("arlen[%0d]", i), 32'(ar.m_arlen[i*8 +: 8]), 32'(mq_len[i][0]));
                end
            end
            if (rd_done === 1'b1) done_cnt++;
            if (|ar.m_arvalid) arvalid_seen++;
        end
    end

    task automatic snap();
        for (int i = 0; i < NUM_AXI; i++) base[i] = obs_addr[i].size();
        done0 = done_cnt;
        seen0 = arvalid_seen;
    endtask

    task automatic issue(input logic [TXW-1:0] sz, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
        @(negedge clk);
        rx_req = 1'b1; rx_req_size = sz; rx_addr = {a3, a2, a1, a0};
        @(negedge clk);
        rx_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (rd_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_in_time"}, 32'(rd_done), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; rx_req = 1'b0; rx_req_size = '0; rx_addr = '0;
        ar.m_arready = 4'hF;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_arvalid", 32'(ar.m_arvalid), 32'd0);
        chk("rst_araddr0", ar.m_araddr[31:0], 32'd0);

        // 128 beats from 0x1000: eight 16-beat bursts per lane
        snap();
        issue(10'd128, 32'h1000, 32'h1000, 32'h1000, 32'h1000);
        wait_done("t128", 1000);
        chk("t128_bursts", 32'(obs_addr[0].size() - base[0]), 32'd8);
        chk("t128_first", obs_addr[0][base[0]], 32'h1000);
        chk("t128_4th", obs_addr[2][base[2] + 3], 32'h1180);
        chk("t128_last", obs_addr[0][base[0] + 7], 32'h1380);
        chk("t128_len", 32'(obs_len[3][base[3] + 5]), 32'd15);
        chk("t128_one_done", 32'(done_cnt - done0), 32'd1);

        // 20 beats: 16 + 4
        snap();
        issue(10'd20, 32'h2000, 32'h3000, 32'h4000, 32'h5000);
        wait_done("t20", 500);
        chk("t20_bursts", 32'(obs_addr[1].size() - base[1]), 32'd2);
        chk("t20_len0", 32'(obs_len[1][base[1]]), 32'd15);
        chk("t20_len1", 32'(obs_len[1][base[1] + 1]), 32'd3);
        chk("t20_addr1", obs_addr[1][base[1] + 1], 32'h3080);

        // address wrap at the top of the space
        snap();
        issue(10'd32, 32'hFFFF_FFC0, 32'h100, 32'h200, 32'h300);
        wait_done("twrap", 500);
        chk("twrap_addr1", obs_addr[0][base[0] + 1], 32'h0000_0040);

        // zero-size request
        snap();
        issue(10'd0, 32'h10, 32'h20, 32'h30, 32'h40);
        chk("t0_done_next_cycle", 32'(rd_done), 32'd1);
        repeat (3) @(negedge clk);
        chk("t0_no_arvalid", 32'(arvalid_seen - seen0), 32'd0);
        chk("t0_one_done", 32'(done_cnt - done0), 32'd1);

        // back-pressure on lane 2, completions withheld
        snap();
        hold = 4'hF; ar.m_arready = 4'b1011;
        issue(10'd128, 32'h4000, 32'h5000, 32'h6000, 32'h7000);
        repeat (50) @(negedge clk);
        chk("bp_lane0_capped", 32'(obs_addr[0].size() - base[0]), 32'd4);
        chk("bp_lane2_none", 32'(obs_addr[2].size() - base[2]), 32'd0);
        chk("bp_lane2_valid", 32'(ar.m_arvalid[2]), 32'd1);
        chk("bp_lane2_addr", ar.m_araddr[2*AW +: AW], 32'h6000);
        chk("bp_lane2_len", 32'(ar.m_arlen[2*8 +: 8]), 32'd15);
        chk("bp_no_done", 32'(done_cnt - done0), 32'd0);
        ar.m_arready = 4'hF; hold = 4'h0;
        wait_done("bp", 2000);
        chk("bp_lane2_bursts", 32'(obs_addr[2].size() - base[2]), 32'd8);
        chk("bp_one_done", 32'(done_cnt - done0), 32'd1);

        // dropped request while busy, then stray rlast while idle
        snap();
        issue(10'd40, 32'h8000, 32'h9000, 32'hA000, 32'hB000);
        repeat (3) @(negedge clk);
        rx_req = 1'b1; rx_req_size = 10'd5; rx_addr = {4{32'hDEAD_0000}};
        @(negedge clk);
        rx_req = 1'b0;
        chk("drop_flag", 32'(err_drop), 32'd1);
        wait_done("drop", 500);
        chk("drop_bursts", 32'(obs_addr[0].size() - base[0]), 32'd3);
        chk("drop_first", obs_addr[0][base[0]], 32'h8000);
        chk("rlast_err_clear", 32'(err_rlast), 32'd0);
        stray = 4'b0010;
        @(negedge clk);
        stray = 4'b0000;
        @(negedge clk);
        chk("rlast_err_set", 32'(err_rlast), 32'd1);

        // reset mid-transfer: no completion, late rlasts flagged
        pulse_reset();
        chk("mrst_flags_clear", 32'({err_drop, err_rlast}), 32'd0);
        snap();
        issue(10'd64, 32'hC000, 32'hC000, 32'hC000, 32'hC000);
        repeat (8) @(negedge clk);
        pulse_reset();
        chk("mrst_ready", 32'(req_ready), 32'd1);
        repeat (60) @(negedge clk);
        chk("mrst_no_done", 32'(done_cnt - done0), 32'd0);
        chk("mrst_late_rlast", 32'(err_rlast), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
